ping_scheduler: RTL and testbench



---
 rtl/ping_scheduler_pkg.sv | 31 +++
 rtl/ping_scheduler_timer.sv | 32 +++
 rtl/ping_scheduler.sv | 163 ++++++++++++++++
 tb/tb_ping_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ping_scheduler_pkg.sv
// ping_scheduler_pkg: state encoding, default timing and sizing helpers shared by
// the ping burst scheduler and its down-counter.
`default_nettype none

package ping_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TRIG   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_REPORT = 3'd4,
      ST_PERIOD = 3'd5
   } state_t;

   // Defaults assume clk = 100 MHz / 256 = 390.625 kHz (2.56 us per cycle).
   localparam int unsigned DEF_HOLDOFF_CYC = 80;     // ~205 us echo decay
   localparam int unsigned DEF_TIMEOUT_CYC = 16000;  // ~41 ms, beyond max echo range
   localparam int unsigned DEF_PERIOD_CYC  = 39000;  // ~100 ms between auto bursts
   localparam int unsigned DEF_CNT_W       = 16;

   localparam int unsigned MAX_AVG_LOG2    = 4;
   localparam int unsigned RESULT_W        = 8;

   function automatic int unsigned idx_width(input int unsigned avg_log2);
      return (avg_log2 == 0) ? 1 : avg_log2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ping_scheduler_timer.sv
// ping_scheduler_timer: loadable down-counter that stops at zero, shared by the
// timeout, holdoff and period phases.
`default_nettype none

module ping_scheduler_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] value_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ping_scheduler.sv
// ping_scheduler: burst sequencer for the ping ultrasonic core. Triggers pings,
// enforces holdoff and timeout, and publishes the mean of 2^AVG_LOG2 samples.
`default_nettype none

module ping_scheduler
   import ping_scheduler_pkg::*;
#(
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                go,
   input  logic                auto_en,
   input  logic                inches_in,
   output logic                ping_go,
   output logic                ping_inches,
   input  logic                ping_done,
   input  logic [RESULT_W-1:0] ping_result,
   output logic [RESULT_W-1:0] result,
   output logic                result_valid,
   output logic                busy,
   output logic                timeout_err,
   output logic [2:0]          state_dbg
);

   localparam int unsigned      ACC_W      = RESULT_W + AVG_LOG2;
   localparam int unsigned      IDX_W      = idx_width(AVG_LOG2);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((32'd1 << AVG_LOG2) - 32'd1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CNT_W-1:0] PERIOD_LD  = CNT_W'(PERIOD_CYC - 1);

   state_t                state_q, state_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [RESULT_W-1:0]   result_q, result_d;
   logic                  err_q, err_d;
   logic                  inches_q, inches_d;
   logic [ACC_W-1:0]      sum;
   logic                  start;
   logic                  tmr_load;
   logic                  tmr_en;
   logic                  tmr_zero;
   logic [CNT_W-1:0]      tmr_val;

   ping_scheduler_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (tmr_load),
      .value_i (tmr_val),
      .en_i    (tmr_en),
      .zero_o  (tmr_zero)
   );

   assign sum = acc_q + ACC_W'(ping_result);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         inches_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         err_q    <= err_d;
         inches_q <= inches_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      err_d    = err_q;
      inches_d = inches_q;
      start    = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = '0;

      case (state_q)
         ST_IDLE: begin
            if (go || auto_en) start = 1'b1;
         end
         ST_TRIG: begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LD;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the expiry cycle still counts as a sample.
            if (ping_done) begin
               acc_d = sum;
               if (idx_q == LAST_IDX) begin
                  result_d = sum[AVG_LOG2 +: RESULT_W];
                  state_d  = ST_REPORT;
               end else begin
                  idx_d    = idx_q + 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = HOLDOFF_LD;
                  state_d  = ST_HOLD;
               end
            end else if (tmr_zero) begin
               err_d    = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = PERIOD_LD;
               state_d  = auto_en ? ST_PERIOD : ST_IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) state_d = ST_TRIG;
            else          tmr_en  = 1'b1;
         end
         ST_REPORT: begin
            tmr_load = 1'b1;
            tmr_val  = PERIOD_LD;
            state_d  = auto_en ? ST_PERIOD : ST_IDLE;
         end
         ST_PERIOD: begin
            if (!auto_en)      state_d = ST_IDLE;
            else if (tmr_zero) start   = 1'b1;
            else               tmr_en  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (start) begin
         acc_d    = '0;
         idx_d    = '0;
         err_d    = 1'b0;
         inches_d = inches_in;
         state_d  = ST_TRIG;
      end
   end

   always_comb begin
      ping_go      = (state_q == ST_TRIG);
      result_valid = (state_q == ST_REPORT);
      busy         = (state_q != ST_IDLE);
      state_dbg    = state_q;
   end

   assign ping_inches = inches_q;
   assign result      = result_q;
   assign timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ping_scheduler.sv
// tb_ping_scheduler: directed scenarios plus randomized traffic against a
// phase/duration model of the scheduler, with a ping core responder.
`default_nettype none

module tb_ping_scheduler;

   localparam int L2  = 2;
   localparam int N   = 4;
   localparam int HLD = 4;
   localparam int TMO = 20;
   localparam int PER = 10;

   localparam int PH_IDLE = 0, PH_TRIG = 1, PH_WAIT = 2, PH_HOLD = 3, PH_REPORT = 4, PH_PERIOD = 5;

   logic       clk, reset_n, go, auto_en, inches_in, ping_done;
   logic [7:0] ping_result, result;
   logic       ping_go, ping_inches, result_valid, busy, timeout_err;
   logic [2:0] state_dbg;

   logic       z_go, z_auto, z_inches, z_done;
   logic [7:0] z_res, z_result;
   logic       z_ping_go, z_ping_inches, z_valid, z_busy, z_err;
   logic [2:0] z_dbg;

   ping_scheduler #(.AVG_LOG2(L2), .HOLDOFF_CYC(HLD), .TIMEOUT_CYC(TMO), .PERIOD_CYC(PER), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .auto_en(auto_en), .inches_in(inches_in),
      .ping_go(ping_go), .ping_inches(ping_inches), .ping_done(ping_done), .ping_result(ping_result),
      .result(result), .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err),
      .state_dbg(state_dbg));

   ping_scheduler #(.AVG_LOG2(0), .HOLDOFF_CYC(HLD), .TIMEOUT_CYC(TMO), .PERIOD_CYC(PER), .CNT_W(16)) dut_n1 (
      .clk(clk), .reset_n(reset_n), .go(z_go), .auto_en(z_auto), .inches_in(z_inches),
      .ping_go(z_ping_go), .ping_inches(z_ping_inches), .ping_done(z_done), .ping_result(z_res),
      .result(z_result), .result_valid(z_valid), .busy(z_busy), .timeout_err(z_err),
      .state_dbg(z_dbg));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_go   = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase, m_left, m_sum, m_cnt, m_result;
   bit m_err, m_inches;

   task automatic model_start();
      m_sum    = 0;
      m_cnt    = 0;
      m_err    = 1'b0;
      m_inches = inches_in;
      m_phase  = PH_TRIG;
   endtask

   task automatic model_step();
      case (m_phase)
         PH_IDLE: if (go || auto_en) model_start();
         PH_TRIG: begin m_phase = PH_WAIT; m_left = TMO; end
         PH_WAIT: begin
            if (ping_done) begin
               m_sum += int'(ping_result);
               m_cnt++;
               if (m_cnt == N) begin
                  m_result = m_sum / N;
                  m_phase  = PH_REPORT;
               end else begin
                  m_phase = PH_HOLD;
                  m_left  = HLD;
               end
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_err   = 1'b1;
                  m_left  = PER;
                  m_phase = auto_en ? PH_PERIOD : PH_IDLE;
               end
            end
         end
         PH_HOLD: begin
            m_left--;
            if (m_left == 0) m_phase = PH_TRIG;
         end
         PH_REPORT: begin
            m_left  = PER;
            m_phase = auto_en ? PH_PERIOD : PH_IDLE;
         end
         PH_PERIOD: begin
            if (!auto_en) m_phase = PH_IDLE;
            else begin
               m_left--;
               if (m_left == 0) model_start();
            end
         end
         default: m_phase = PH_IDLE;
      endcase
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = PH_IDLE; m_left = 0; m_sum = 0; m_cnt = 0;
         m_result = 0; m_err = 1'b0; m_inches = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (ping_go === 1'b1) n_go++;
      checks++;
      if (ping_go !== (m_phase == PH_TRIG) || result_valid !== (m_phase == PH_REPORT) ||
          busy !== (m_phase != PH_IDLE) || state_dbg !== 3'(m_phase) ||
          result !== 8'(m_result) || timeout_err !== m_err || ping_inches !== m_inches) begin
         errors++;
         $display("FAIL cycle_compare t=%0t dut(st=%0d go=%b v=%b busy=%b res=%0d err=%b inch=%b) model(st=%0d res=%0d err=%b inch=%b)",
                  $time, state_dbg, ping_go, result_valid, busy, result, timeout_err, ping_inches,
                  m_phase, m_result, m_err, m_inches);
      end
   end

   // ---------------- ping core responder ----------------
   typedef struct { int val; int dly; bit drop; } resp_t;
   resp_t resp_q[$];
   int    pend = 0, pend_val = 0, inj_val = 0;
   bit    inj = 1'b0, spurious = 1'b0;

   initial begin
      resp_t r;
      ping_done   = 1'b0;
      ping_result = 8'd0;
      forever begin
         @(posedge clk); #1;
         ping_done = 1'b0;
         if (!reset_n) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin ping_done = 1'b1; ping_result = 8'(pend_val); end
            end else if (inj) begin
               inj = 1'b0; ping_done = 1'b1; ping_result = 8'(inj_val);
            end else if (spurious && $urandom_range(0, 31) == 0) begin
               ping_done = 1'b1; ping_result = 8'($urandom_range(0, 255));
            end
            if (ping_go === 1'b1) begin
               if (resp_q.size() > 0) r = resp_q.pop_front();
               else begin
                  r.val  = int'($urandom_range(0, 255));
                  r.dly  = int'($urandom_range(1, 22));
                  r.drop = ($urandom_range(0, 19) == 0);
               end
               if (!r.drop) begin pend = r.dly; pend_val = r.val; end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_go();
      go = 1'b1; step(); go = 1'b0;
   endtask

   task automatic push(input int v, input int d, input bit drop, input int n = 1);
      resp_t r;
      r.val = v; r.dly = d; r.drop = drop;
      repeat (n) resp_q.push_back(r);
   endtask

   task automatic wait_valid(input string name, input int maxc);
      bit ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (result_valid === 1'b1) begin ok = 1'b1; break; end
         step();
      end
      check({name, "_valid_seen"}, int'(ok), 1);
   endtask

   task automatic run_burst1(input string tag);
      int g0;
      push(10, 2, 1'b0); push(11, 3, 1'b0); push(12, 1, 1'b0); push(13, 5, 1'b0);
      g0 = n_go;
      pulse_go();
      wait_valid(tag, 300);
      check({tag, "_result"}, int'(result), 11);
      check({tag, "_pings"}, n_go - g0, 4);
      step();
      check({tag, "_valid_one_cycle"}, int'(result_valid), 0);
      check({tag, "_busy_drop"}, int'(busy), 0);
      check({tag, "_timeout_err"}, int'(timeout_err), 0);
   endtask

   initial begin
      int g0, seen, t2, te, r;
      bit saw_v;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int g0, seen, t2, te, cnt;
      bit saw_v;
      reset_n = 1'b0; go = 1'b0; auto_en = 1'b0; inches_in = 1'b0;
      z_go = 1'b0; z_auto = 1'b0; z_inches = 1'b0; z_done = 1'b0; z_res = 8'd0;
      step(3);
      reset_n = 1'b1;
      step();
      check("reset_state", int'(state_dbg), 0);
      check("reset_result", int'(result), 0);
      check("reset_busy", int'(busy), 0);

      // 1: single burst, mean of 10..13
      run_burst1("burst1");

      // 2: second ping lost
      push(10, 2, 1'b0); push(0, 0, 1'b1);
      seen = 0; t2 = -1; te = -1; saw_v = 1'b0;
      pulse_go();
      for (int i = 0; i < 200; i++) begin
         if (timeout_err === 1'b1) begin te = i; break; end
         if (ping_go === 1'b1) begin seen++; if (seen == 2) t2 = i; end
         if (result_valid === 1'b1) saw_v = 1'b1;
         step();
      end
      check("timeout_seen", int'(te >= 0), 1);
      // ping_go cycle followed by TMO wait cycles; flag shows in the next one
      check("timeout_latency", te - t2, TMO + 1);
      check("timeout_no_valid", int'(saw_v), 0);
      check("timeout_result_hold", int'(result), 11);
      check("timeout_busy", int'(busy), 0);
      push(1, 2, 1'b0, 1); push(2, 2, 1'b0, 1); push(3, 2, 1'b0, 1); push(4, 2, 1'b0, 1);
      pulse_go();
      check("timeout_cleared", int'(timeout_err), 0);
      wait_valid("after_timeout", 300);
      check("after_timeout_result", int'(result), 2);

      // 3: auto mode
      step(3);
      push(200, 3, 1'b0, 8);
      auto_en = 1'b1;
      wait_valid("auto1", 300);
      check("auto1_result", int'(result), 200);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(); cnt++;
         if (ping_go === 1'b1) break;
      end
      check("auto_period_gap", cnt, PER + 1);
      wait_valid("auto2", 300);
      check("auto2_result", int'(result), 200);
      step(2);
      auto_en = 1'b0;
      step();
      check("auto_stop_idle", int'(state_dbg), 0);
      g0 = n_go;
      step(30);
      check("auto_stop_no_go", n_go - g0, 0);

      // 4: full scale, and single-sample instance
      push(255, 2, 1'b0, 4);
      pulse_go();
      wait_valid("full", 300);
      check("full_result", int'(result), 255);
      step(2);
      z_go = 1'b1; step(); z_go = 1'b0;
      check("n1_ping_go", int'(z_ping_go), 1);
      step(3);
      z_done = 1'b1; z_res = 8'd7;
      step();
      z_done = 1'b0;
      check("n1_valid", int'(z_valid), 1);
      check("n1_result", int'(z_result), 7);
      step();
      check("n1_idle", int'(z_busy) + int'(z_err) + int'(z_dbg) + int'(z_ping_inches), 0);

      // 5a: go during WAIT ignored
      push(20, 5, 1'b0, 4);
      g0 = n_go;
      pulse_go();
      step(2);
      pulse_go();
      wait_valid("go_in_wait", 300);
      check("go_in_wait_result", int'(result), 20);
      step(8);
      check("go_in_wait_pings", n_go - g0, 4);
      // 5b: done while idle
      inj_val = 99; inj = 1'b1;
      step(3);
      check("done_idle_result", int'(result), 20);
      check("done_idle_busy", int'(busy), 0);
      // 5c: done on the last WAIT cycle
      push(40, TMO, 1'b0); push(40, 1, 1'b0, 3);
      pulse_go();
      wait_valid("edge_done", 300);
      check("edge_done_result", int'(result), 40);
      check("edge_done_no_err", int'(timeout_err), 0);
      step(2);
      // 5d: inches_in mid-burst
      inches_in = 1'b1;
      push(8, 2, 1'b0, 8);
      pulse_go();
      step(3);
      inches_in = 1'b0;
      step();
      check("inches_latched", int'(ping_inches), 1);
      wait_valid("inches", 300);
      check("inches_held", int'(ping_inches), 1);
      step(2);
      pulse_go();
      check("inches_next_burst", int'(ping_inches), 0);
      wait_valid("inches2", 300);
      step(2);

      // 6: asynchronous reset mid-WAIT
      inches_in = 1'b1;
      push(5, 10, 1'b0);
      pulse_go();
      step(3);
      inches_in = 1'b0;
      reset_n = 1'b0;
      #1;
      check("rst_async_state", int'(state_dbg), 0);
      check("rst_async_outs", int'(busy) + int'(ping_go) + int'(result_valid) + int'(timeout_err) + int'(ping_inches), 0);
      check("rst_async_result", int'(result), 0);
      step(2);
      reset_n = 1'b1;
      resp_q.delete();
      step();
      run_burst1("post_reset");

      // randomized traffic
      spurious = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         go = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 149) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 19) == 0) inches_in = ~inches_in;
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0; step(); reset_n = 1'b1;
         end else begin
            step();
         end
      end
      go = 1'b0; auto_en = 1'b0; spurious = 1'b0;
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
